// File: rtl/demux_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// demux_pkg : shared constants and state type for the capture bank  (rev 1.0)
// ----------------------------------------------------------------------------
package demux_pkg;

  localparam int NUM_CH     = 4;
  localparam int SEL_W      = 2;
  localparam int CW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2,
    ERROR  = 2'd3
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/channel_cell.sv
`default_nettype none
// ----------------------------------------------------------------------------
// channel_cell : one holding bit plus a saturating write counter     (rev 1.0)
// ----------------------------------------------------------------------------
module channel_cell
  import demux_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          d,
  input  logic          clr,
  output logic          q,
  output logic [CW-1:0] count
);

  logic          q_q, q_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    q_d     = q_q;
    count_d = count_q;
    if (clr) begin
      q_d     = 1'b0;
      count_d = '0;
    end else if (wr_en) begin
      q_d = d;
      // Saturate at all-ones rather than wrapping.
      if (count_q != {CW{1'b1}}) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    q_q     <= q_d;
    count_q <= count_d;
  end

  assign q     = q_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/demux_capture_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// demux_capture_bank : routed-line capture with run/freeze/error FSM (rev 1.0)
// ----------------------------------------------------------------------------
module demux_capture_bank
  import demux_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              freeze,
  input  logic              clear,
  input  logic              valid_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic [NUM_CH-1:0] y,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [NUM_CH-1:0] q,
  output logic [CW-1:0]     rd_count,
  output logic              active,
  output logic              frozen,
  output logic              err
);

  cap_state_t        state_q, state_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] sel_oh;
  logic              violation;
  logic              wr_ok;
  logic              clr_all;
  logic [NUM_CH-1:0] wr_en;
  logic [CW-1:0]     count_w [NUM_CH];

  assign clr_all = reset | clear;

  // Any asserted line other than the selected one means the demux misrouted.
  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
    violation   = |(y & ~sel_oh);
    wr_ok       = (state_q == RUN) && valid_in && !violation && !clr_all;
    wr_en       = wr_ok ? sel_oh : '0;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (clr_all) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_d = RUN;
        end
        RUN: begin
          if (valid_in && violation) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (!enable) begin
            state_d = IDLE;
          end else if (freeze) begin
            state_d = FROZEN;
          end
        end
        FROZEN: begin
          if (!enable)      state_d = IDLE;
          else if (!freeze) state_d = RUN;
        end
        ERROR: begin
          state_d = ERROR;
          err_d   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      channel_cell #(.CW(CW)) u_cell (
        .clk   (clk),
        .wr_en (wr_en[k]),
        .d     (y[k]),
        .clr   (clr_all),
        .q     (q[k]),
        .count (count_w[k])
      );
    end
  endgenerate

  assign rd_count = count_w[rd_sel];
  assign active   = (state_q == RUN);
  assign frozen   = (state_q == FROZEN);
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_capture_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_demux_capture_bank : directed vector bench for the capture bank (rev 1.0)
// ----------------------------------------------------------------------------
module tb_demux_capture_bank;

  localparam int CW = 4;
  localparam int NV = 20;

  logic          clk = 1'b0;
  logic          reset, enable, freeze, clear, valid_in;
  logic [1:0]    sel, rd_sel;
  logic [3:0]    y;
  logic [3:0]    q;
  logic [CW-1:0] rd_count;
  logic          active, frozen, err;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic       rst, en, frz, clr, vld;
    logic [1:0] sel;
    logic [3:0] y;
    logic [1:0] rd;
    logic [3:0] eq;
    logic [3:0] ecnt;
    logic       eact, efrz, eerr;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  demux_capture_bank #(.CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .freeze   (freeze),
    .clear    (clear),
    .valid_in (valid_in),
    .sel      (sel),
    .y        (y),
    .rd_sel   (rd_sel),
    .q        (q),
    .rd_count (rd_count),
    .active   (active),
    .frozen   (frozen),
    .err      (err)
  );

  function automatic vec_t mk(logic rst_i, logic en_i, logic frz_i, logic clr_i, logic vld_i,
                              logic [1:0] sel_i, logic [3:0] y_i, logic [1:0] rd_i,
                              logic [3:0] eq_i, logic [3:0] ecnt_i,
                              logic eact_i, logic efrz_i, logic eerr_i);
    vec_t v;
    v.rst = rst_i; v.en = en_i; v.frz = frz_i; v.clr = clr_i; v.vld = vld_i;
    v.sel = sel_i; v.y = y_i; v.rd = rd_i;
    v.eq = eq_i; v.ecnt = ecnt_i; v.eact = eact_i; v.efrz = efrz_i; v.eerr = eerr_i;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic drive(input logic rst_i, input logic en_i, input logic frz_i, input logic clr_i,
                       input logic vld_i, input logic [1:0] sel_i, input logic [3:0] y_i,
                       input logic [1:0] rd_i);
    reset = rst_i; enable = en_i; freeze = frz_i; clear = clr_i;
    valid_in = vld_i; sel = sel_i; y = y_i; rd_sel = rd_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst en frz clr vld sel    y        rd     q        cnt   act frz err
    vecs[0]  = mk(1, 0, 0, 0, 0, 2'd0, 4'b0000, 2'd0, 4'b0000, 4'd0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 2'd0, 4'b0000, 2'd0, 4'b0000, 4'd0, 1, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 1, 2'd2, 4'b0100, 2'd2, 4'b0100, 4'd1, 1, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 1, 2'd0, 4'b0001, 2'd0, 4'b0101, 4'd1, 1, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 1, 2'd1, 4'b0011, 2'd1, 4'b0101, 4'd0, 0, 0, 1);
    vecs[5]  = mk(0, 1, 0, 0, 1, 2'd1, 4'b0010, 2'd1, 4'b0101, 4'd0, 0, 0, 1);
    vecs[6]  = mk(0, 1, 0, 0, 0, 2'd0, 4'b0000, 2'd2, 4'b0101, 4'd1, 0, 0, 1);
    vecs[7]  = mk(0, 1, 0, 1, 0, 2'd0, 4'b0000, 2'd2, 4'b0000, 4'd0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 2'd0, 4'b0000, 2'd1, 4'b0000, 4'd0, 1, 0, 0);
    vecs[9]  = mk(0, 1, 1, 0, 1, 2'd1, 4'b0010, 2'd1, 4'b0010, 4'd1, 0, 1, 0);
    vecs[10] = mk(0, 1, 1, 0, 1, 2'd1, 4'b0000, 2'd1, 4'b0010, 4'd1, 0, 1, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 2'd0, 4'b0000, 2'd3, 4'b0010, 4'd0, 1, 0, 0);
    vecs[12] = mk(0, 1, 0, 0, 1, 2'd3, 4'b1000, 2'd3, 4'b1010, 4'd1, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 1, 2'd3, 4'b0000, 2'd3, 4'b0010, 4'd2, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 2'd1, 4'b0000, 2'd1, 4'b0010, 4'd1, 0, 0, 0);
    vecs[15] = mk(0, 1, 0, 0, 0, 2'd0, 4'b0000, 2'd1, 4'b0010, 4'd1, 1, 0, 0);
    vecs[16] = mk(0, 1, 0, 1, 1, 2'd1, 4'b0010, 2'd1, 4'b0000, 4'd0, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 0, 0, 2'd0, 4'b0000, 2'd3, 4'b0000, 4'd0, 1, 0, 0);
    vecs[18] = mk(0, 1, 1, 0, 0, 2'd0, 4'b0000, 2'd3, 4'b0000, 4'd0, 0, 1, 0);
    vecs[19] = mk(1, 1, 1, 0, 1, 2'd0, 4'b0001, 2'd0, 4'b0000, 4'd0, 0, 0, 0);

    reset = 1'b1; enable = 1'b0; freeze = 1'b0; clear = 1'b0;
    valid_in = 1'b0; sel = '0; y = '0; rd_sel = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].frz, vecs[i].clr, vecs[i].vld,
            vecs[i].sel, vecs[i].y, vecs[i].rd);
      check($sformatf("v%0d_q", i),      32'(q),        32'(vecs[i].eq));
      check($sformatf("v%0d_cnt", i),    32'(rd_count), 32'(vecs[i].ecnt));
      check($sformatf("v%0d_active", i), 32'(active),   32'(vecs[i].eact));
      check($sformatf("v%0d_frozen", i), 32'(frozen),   32'(vecs[i].efrz));
      check($sformatf("v%0d_err", i),    32'(err),      32'(vecs[i].eerr));
    end

    // Saturation: 20 back-to-back writes to channel 3.
    drive(1, 0, 0, 0, 0, 2'd0, 4'b0000, 2'd3);
    drive(0, 1, 0, 0, 0, 2'd0, 4'b0000, 2'd3);
    for (int n = 1; n <= 20; n++) begin
      drive(0, 1, 0, 0, 1, 2'd3, 4'b1000, 2'd3);
      check($sformatf("sat_w%0d", n), 32'(rd_count), (n > 15) ? 32'd15 : 32'(n));
    end
    check("sat_q", 32'(q), 32'h8);
    for (int c = 0; c < 3; c++) begin
      rd_sel = 2'(c);
      #1;
      check($sformatf("sat_other%0d", c), 32'(rd_count), 32'd0);
    end
    rd_sel = 2'd3;
    #1;
    check("sat_final", 32'(rd_count), 32'd15);

    // A violation on the saturated channel must not disturb it.
    drive(0, 1, 0, 0, 1, 2'd3, 4'b1001, 2'd3);
    check("sat_viol_cnt", 32'(rd_count), 32'd15);
    check("sat_viol_err", 32'(err), 32'd1);
    drive(0, 0, 0, 1, 0, 2'd0, 4'b0000, 2'd3);
    check("sat_clear_cnt", 32'(rd_count), 32'd0);
    check("sat_clear_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_capture_bank.md
# demux_capture_bank

Four-channel capture stage directly downstream of the 1-to-4 demultiplexer. It samples the four routed lines on a valid strobe and latches the selected channel's bit into a per-channel holding register. Each channel also keeps a saturating write counter. A small state machine provides enable, freeze and sticky routing-error detection. Outputs drive board LEDs and the next lab stage.

## Interface
Parameters:
- CW, 4, width of each per-channel write counter; counters saturate at 2^CW-1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- enable  in  1  level; allows leaving IDLE and remaining in RUN.
- freeze  in  1  level; holds captured data while high in RUN.
- clear  in  1  synchronous soft clear; same effect as reset.
- valid_in  in  1  demux outputs are meaningful this cycle.
- sel  in  2  same select driving the demux; identifies the target channel.
- y  in  4  demux outputs, y[0]=Y1 … y[3]=Y4.
- rd_sel  in  2  channel whose counter appears on rd_count.
- q  out  4  latched channel values, q[k] for channel k.
- rd_count  out  CW  write count of channel rd_sel.
- active  out  1  high while state is RUN.
- frozen  out  1  high while state is FROZEN.
- err  out  1  sticky routing error.

## Operation
- States: IDLE, RUN, FROZEN, ERROR.
- Reset and clear (also in ERROR) force the following:
  - State goes to IDLE.
  - q, all counters and err are set to 0.
  - clear outranks every other input; reset outranks clear.
- IDLE:
  - valid_in is ignored.
  - enable=1 moves to RUN next cycle.
  - q and the counters are retained.
- RUN with valid_in=1, routing check:
  - A routing violation is any y[k]=1 with k≠sel.
  - Legal: q[sel] takes y[sel], and count[sel] increments with saturation.
  - Violation: no write and no count change; err becomes 1 and the state moves to ERROR.
- Other channels' q and count never change on a write.
- A write of 0 is legal and still increments the counter.
- RUN transitions, evaluated after the write:
  - enable=0 moves to IDLE; takes precedence over freeze.
  - Otherwise freeze=1 moves to FROZEN.
  - A valid write in the same cycle as either transition is still performed.
- FROZEN:
  - valid_in is ignored.
  - freeze=0 with enable=1 returns to RUN.
  - enable=0 moves to IDLE.
- ERROR:
  - All writes are ignored.
  - err stays 1; only reset or clear leaves this state.
- Counter arithmetic:
  - Unsigned, CW bits.
  - Increment only when count < 2^CW-1; otherwise hold, with no wrap.

## Timing
- Inputs are sampled on the rising edge.
- q, counters, err and state update on that same edge, so outputs reflect a write one cycle after valid_in is presented.
- rd_count is combinational from the registered counters via rd_sel, with zero-cycle select latency.
- active and frozen decode the registered state.
- Back-to-back valid_in on consecutive cycles is fully supported; there is no backpressure.
- Reset values: q=0000, rd_count=0, active=0, frozen=0, err=0.
- Reset or clear asserted mid-burst discards that cycle's write.
- The first accepted write after re-enable needs enable high for one cycle, to get IDLE→RUN, before valid_in is honoured.

## Structure
- Shared package demux_pkg holds:
  - NUM_CH=4.
  - State enum cap_state_t {IDLE, RUN, FROZEN, ERROR}.
  - Default CW.
- Sub-module channel_cell, instantiated NUM_CH times, contains:
  - Ports: wr_en, d, clr, q bit, saturating CW-bit counter.
- Top level contains the FSM, the routing check, the write-enable decode from sel, and the rd_count mux.

## Test plan
- Reset, enable=1, then writes:
  - (sel=2, y=0100) gives q=0100 and count[2]=1.
  - Then (sel=0, y=0001) gives q=0101.
- Routing error:
  - In RUN, valid_in with sel=1, y=0011 gives err=1 and state ERROR.
  - q and counters are unchanged.
  - Further valid writes are ignored until clear.
  - clear gives err=0, q=0000, and IDLE.
- Saturation:
  - 20 consecutive writes to channel 3 with CW=4 give rd_count=15 at rd_sel=3.
  - The other counts stay 0.
- Freeze with write:
  - In RUN, valid_in (sel=1, y=0010) with freeze=1 in the same cycle gives q[1]=1 and frozen=1.
  - A subsequent write (sel=1, y=0000) is ignored; q[1] stays 1.
- Enable drop:
  - Deassert enable during a burst; the write in that cycle lands and the state goes to IDLE.
  - Later valid_in is ignored; q is retained.
- Priority:
  - clear and valid_in in the same cycle leave q=0000 and all counts 0.
  - reset asserted during FROZEN gives all outputs their reset values the next cycle.
